// File: rtl/aes_bist_ctrl.sv
// BIST sequencer for the 8-bit AES core: resets the core, runs LFSR/MISR until
// DONE, drains the MISR, then captures and judges the signature.
module aes_bist_ctrl #(
    parameter int               SIG_W        = 8,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = 8'hC0,
    parameter int               RST_CYCLES   = 4,
    parameter int               DRAIN_CYCLES = 2,
    parameter int               TIMEOUT      = 2048,
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_done,
    input  logic [SIG_W-1:0] sig_in,
    output logic             dut_rst,
    output logic             is_bist,
    output logic             en_lsfr_misr,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [SIG_W-1:0] sig_out,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int PH_MAX     = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int PH_W       = $clog2(PH_MAX + 1);
    localparam int TO_W       = $clog2(TIMEOUT + 1);
    localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    localparam logic [PH_W-1:0] RST_END   = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] DRAIN_END = PH_W'(DRAIN_LAST);
    localparam logic [TO_W-1:0] RUN_END   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_DUT,
        S_RUN,
        S_DRAIN,
        S_COMPARE,
        S_RESULT
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [PH_W-1:0] phase_cnt;
    logic [TO_W-1:0] run_cnt;
    logic            kill;
    logic            launch;
    logic            run_expired;

    assign kill        = abort && (state != S_IDLE);
    assign launch      = start && ((state == S_IDLE) || (state == S_RESULT));
    assign run_expired = (state == S_RUN) && !dut_done && (run_cnt == RUN_END);

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    if (start) next_state = S_RST_DUT;
            S_RST_DUT: if (phase_cnt == RST_END) next_state = S_RUN;
            S_RUN: begin
                // DONE on the final budget cycle still counts as a normal finish
                if (dut_done)
                    next_state = (DRAIN_CYCLES == 0) ? S_COMPARE : S_DRAIN;
                else if (run_cnt == RUN_END)
                    next_state = S_RESULT;
            end
            S_DRAIN:   if (phase_cnt == DRAIN_END) next_state = S_COMPARE;
            S_COMPARE: next_state = S_RESULT;
            S_RESULT:  if (start) next_state = S_RST_DUT;
            default:   next_state = S_IDLE;
        endcase
        if (kill) next_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            run_cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                phase_cnt <= '0;
            else
                phase_cnt <= phase_cnt + PH_W'(1);
            if (state == S_RUN)
                run_cnt <= run_cnt + TO_W'(1);
            else
                run_cnt <= '0;
        end
    end

    // Control outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dut_rst      <= 1'b0;
            is_bist      <= 1'b0;
            en_lsfr_misr <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            dut_rst      <= (next_state == S_RST_DUT);
            is_bist      <= (next_state != S_IDLE);
            en_lsfr_misr <= (next_state == S_RUN) || (next_state == S_DRAIN);
            busy         <= (next_state != S_IDLE) && (next_state != S_RESULT);
            done         <= (next_state == S_RESULT) && (state != S_RESULT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            sig_out   <= '0;
            cycle_cnt <= '0;
        end else if (kill || launch) begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            sig_out   <= '0;
            cycle_cnt <= '0;
        end else begin
            if (state == S_RUN && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (run_expired) begin
                timeout <= 1'b1;
                fail    <= 1'b1;
                sig_out <= sig_in;
            end
            if (state == S_COMPARE) begin
                sig_out <= sig_in;
                pass    <= (sig_in == GOLDEN_SIG);
                fail    <= (sig_in != GOLDEN_SIG);
            end
        end
    end

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// Bench for aes_bist_ctrl: directed and randomized BIST runs judged against
// cycle counts and verdicts derived from the run parameters.
module tb_aes_bist_ctrl;

    localparam int         SIG_W        = 8;
    localparam logic [7:0] GOLDEN       = 8'hC0;
    localparam int         RST_CYCLES   = 4;
    localparam int         DRAIN_CYCLES = 2;
    localparam int         TIMEOUT      = 2048;
    localparam int         CNT_W        = 16;
    localparam int         BOUND        = 5000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             dut_done = 1'b0;
    logic [SIG_W-1:0] sig_in = '0;
    logic             dut_rst;
    logic             is_bist;
    logic             en_lsfr_misr;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [SIG_W-1:0] sig_out;
    logic [CNT_W-1:0] cycle_cnt;

    int compared = 0;
    int mismatched = 0;

    aes_bist_ctrl #(
        .SIG_W(SIG_W), .GOLDEN_SIG(GOLDEN), .RST_CYCLES(RST_CYCLES),
        .DRAIN_CYCLES(DRAIN_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_done(dut_done), .sig_in(sig_in), .dut_rst(dut_rst),
        .is_bist(is_bist), .en_lsfr_misr(en_lsfr_misr), .busy(busy),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .sig_out(sig_out), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] packed_out;
        packed_out = {dut_rst, is_bist, en_lsfr_misr, busy, done, pass, fail, timeout};
        check({tag, "_ctl"}, packed_out, 32'h0);
        check({tag, "_sig"}, 32'(sig_out), 32'h0);
        check({tag, "_cnt"}, 32'(cycle_cnt), 32'h0);
    endtask

    // Verdict invariants hold on every sampled cycle out of reset
    always @(negedge clk) begin
        if (rst) begin
            compared++;
            assert (!(pass && fail)) else begin
                mismatched++;
                $error("[TB] FAIL pass_fail_excl: observed pass=%0b fail=%0b expected not both", pass, fail);
            end
            if (done) begin
                compared++;
                assert (pass ^ fail) else begin
                    mismatched++;
                    $error("[TB] FAIL done_verdict: observed pass=%0b fail=%0b expected exactly one", pass, fail);
                end
            end
        end
    end

    // One full run, entered just after a falling edge from IDLE or RESULT.
    // n_done: enabled cycle on which DONE is raised (0 = never).
    // start_at: enabled cycle on which a stray start pulse is driven (0 = none).
    task automatic applyStimulus(input int n_done, input logic [7:0] sig,
                                 input int start_at, input bit hold);
        int  rst_seen;
        int  en_seen;
        int  cyc;
        bit  to_exp;
        int  exp_cnt;
        int  exp_en;
        to_exp   = (n_done == 0) || (n_done > TIMEOUT);
        exp_cnt  = to_exp ? TIMEOUT : n_done;
        exp_en   = to_exp ? TIMEOUT : n_done + DRAIN_CYCLES;
        sig_in   = sig;
        start    = 1'b1;
        dut_done = 1'b0;
        @(negedge clk);
        check("launch_rst", 32'(dut_rst), 32'h1);
        check("launch_busy", 32'(busy), 32'h1);
        check("launch_clear", 32'({pass, fail, timeout, done}), 32'h0);
        check("launch_sig", 32'(sig_out), 32'h0);
        check("launch_cnt", 32'(cycle_cnt), 32'h0);
        rst_seen = 1;
        en_seen  = 0;
        cyc      = 0;
        if (!hold) start = 1'b0;
        while (cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (dut_rst) rst_seen++;
            if (en_lsfr_misr) en_seen++;
            if (done) break;
            dut_done = (n_done > 0) && en_lsfr_misr && (en_seen == n_done);
            start    = hold || ((start_at > 0) && (en_seen == start_at));
        end
        dut_done = 1'b0;
        check("run_bound", 32'(cyc < BOUND), 32'h1);
        checkOutput(rst_seen, en_seen, sig, to_exp, exp_cnt, exp_en);
    endtask

    task automatic checkOutput(input int rst_seen, input int en_seen, input logic [7:0] sig,
                               input bit to_exp, input int exp_cnt, input int exp_en);
        bit exp_pass;
        exp_pass = !to_exp && (sig == GOLDEN);
        check("rst_cycles", 32'(rst_seen), 32'(RST_CYCLES));
        check("en_cycles", 32'(en_seen), 32'(exp_en));
        check("done_pulse", 32'(done), 32'h1);
        check("pass", 32'(pass), 32'(exp_pass));
        check("fail", 32'(fail), 32'(!exp_pass));
        check("timeout", 32'(timeout), 32'(to_exp));
        check("sig_out", 32'(sig_out), 32'(sig));
        check("cycle_cnt", 32'(cycle_cnt), 32'(exp_cnt));
        check("result_ctl", 32'({busy, en_lsfr_misr, is_bist}), 32'h1);
    endtask

    initial begin
        logic [7:0] rsig;
        int         rn;
        $display("[TB] reset phase");
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        $display("[TB] pass run");
        applyStimulus(100, 8'hC0, 0, 1'b0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'h0);
        check("result_hold", 32'({pass, is_bist}), 32'h3);

        $display("[TB] restart from RESULT with mismatch");
        applyStimulus(100, 8'h3C, 0, 1'b0);

        $display("[TB] stray start during RUN");
        applyStimulus(60, 8'hC0, 10, 1'b0);

        $display("[TB] DONE on the final budget cycle");
        applyStimulus(TIMEOUT, 8'hC0, 0, 1'b0);

        $display("[TB] timeout run");
        applyStimulus(0, 8'h5A, 0, 1'b0);

        $display("[TB] randomized runs");
        for (int k = 0; k < 6; k++) begin
            rn   = $urandom_range(300, 1);
            rsig = ($urandom_range(1, 0) == 1) ? GOLDEN : 8'($urandom);
            applyStimulus(rn, rsig, 0, 1'b0);
        end

        $display("[TB] abort from RESULT clears results");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_all_zero("abort_result");

        $display("[TB] abort during RUN");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int en_seen = 0;
            int cyc = 0;
            while (en_seen < 50 && cyc < BOUND) begin
                @(negedge clk);
                cyc++;
                if (en_lsfr_misr) en_seen++;
            end
            check("abort_reach", 32'(en_seen), 32'd50);
        end
        abort    = 1'b1;
        start    = 1'b1;
        dut_done = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        start    = 1'b0;
        dut_done = 1'b0;
        check_all_zero("abort_run");
        @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'h0);

        $display("[TB] held start reruns after RESULT");
        applyStimulus(30, 8'hC0, 0, 1'b1);
        @(negedge clk);
        check("held_rerun_rst", 32'(dut_rst), 32'h1);
        check("held_rerun_clear", 32'({pass, done}), 32'h0);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_all_zero("held_abort");

        $display("[TB] async reset mid-run");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_reset_en", 32'(en_lsfr_misr), 32'h1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_rst", 32'(dut_rst), 32'h0);
        check("post_reset_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
